amp_seq_ctrl: RTL and testbench
===============================

AMP_SEQ_CTRL -- requirements
Module: amp_seq_ctrl

Interface
REQ-001 Parameter T_EN_CYC, 1200, cycles between amp_nenable release and the first init write.
REQ-002 Parameter T_MUTE_CYC, 240, cycles between amp_nmute assertion and amp_nenable assertion on power-down.
REQ-003 Parameter LOCK_CYC, 4096, consecutive audio_valid-high cycles required before unmute.
REQ-004 Parameter ACK_TO_CYC, 4095, cycles to wait for i2c_ack/i2c_nack before a timeout fault; all parameters SHALL be 1..65535.
REQ-005 clk  in  1  system clock, single clock domain.
REQ-006 resetb  in  1  asynchronous active-low reset.
REQ-007 ena  in  1  top-level enable.
REQ-008 sys_en  in  1  amplifier enable bit from register bank.
REQ-009 audio_valid  in  1  SPDIF receiver lock.
REQ-010 i2c_req  out  1  write request to the amp I2C master.
REQ-011 i2c_addr, i2c_data  out  8 each  amp register address and data.
REQ-012 i2c_ack, i2c_nack  in  1 each  single-cycle completion pulses from the master.
REQ-013 amp_nenable, amp_nmute  out  1 each  amplifier controls, both active low.
REQ-014 busy, fault  out  1 each  status; state_mon  out  3  current state encoding.

Function
REQ-015 Effective enable en = ena AND sys_en, sampled every cycle.
REQ-016 States: OFF, EN_WAIT, INIT, LOCK_WAIT, RUN, MUTE_DN, FAULT; state_mon encodes them as 0..6 in that order.
REQ-017 OFF: amp_nenable=1, amp_nmute=0, busy=0; on en=1, go to EN_WAIT and clear the counter.
REQ-018 EN_WAIT: amp_nenable=0; after T_EN_CYC cycles, go to INIT with table index 0.
REQ-019 INIT: walk the INIT_LEN-entry table; per entry, raise i2c_req with stable addr/data until the cycle ack or nack is sampled; drop req the next cycle; at most one request is outstanding.
REQ-020 On ack, increment the index; after the last entry, go to LOCK_WAIT; an INIT_LEN of 0 skips directly to LOCK_WAIT.
REQ-021 On nack, retry the same entry up to 2 times; a third nack goes to FAULT.
REQ-022 No ack or nack within ACK_TO_CYC cycles of the req rise goes to FAULT; ack and nack together are treated as nack.
REQ-023 LOCK_WAIT: amp_nmute=0; count consecutive audio_valid=1 cycles and reset the count on any 0; reaching LOCK_CYC goes to RUN.
REQ-024 RUN: amp_nmute=1, busy=0; audio_valid=0 forces amp_nmute=0 in the same registered update and returns to LOCK_WAIT.
REQ-025 en=0 in EN_WAIT or LOCK_WAIT goes to OFF next cycle.
REQ-026 en=0 in INIT completes the outstanding transaction (ack, nack or timeout), then goes to OFF with no retry.
REQ-027 en=0 in RUN goes to MUTE_DN.
REQ-028 MUTE_DN: amp_nmute=0 immediately; after T_MUTE_CYC cycles, go to OFF; en returning high during MUTE_DN is ignored until OFF.
REQ-029 FAULT: amp_nenable=1, amp_nmute=0, fault=1, i2c_req=0; exit to OFF only when en=0.
REQ-030 busy=1 in EN_WAIT, INIT, LOCK_WAIT and MUTE_DN.
REQ-031 All outputs are registered; a single 16-bit counter is shared by the timers, saturates, and never wraps.

Reset
REQ-032 resetb low asynchronously forces state OFF, amp_nenable=1, amp_nmute=0, i2c_req=0, i2c_addr=0, i2c_data=0, busy=0, fault=0, counter=0, index=0, retry=0.
REQ-033 Reset mid-transaction drops i2c_req without waiting for ack; a stale ack after reset is ignored in OFF.

Structure
REQ-034 toi2s_pkg holds the amp_seq_state_t enum, the amp_init_entry_t {addr, data} struct, INIT_LEN, and the AMP_INIT_TABLE constant array.
REQ-035 No sub-module; the I2C bit engine is a separate block, amp_i2c_master, connected by the req/ack handshake.

Verification
REQ-036 en 0->1 with T_EN_CYC=10 and a 3-entry table, master acks after 5 cycles each -> nenable falls 1 cycle later, first req at cycle 11, three writes in table order, then LOCK_WAIT.
REQ-037 audio_valid high for 4095 cycles, one low cycle, then high 4096 cycles -> nmute rises exactly once, 4096 cycles after the low cycle.
REQ-038 Entry 1 nacked 3 times -> 3 requests for the same addr/data, then fault=1, nenable=1; en=0 -> OFF, fault=0.
REQ-039 No response, ACK_TO_CYC=20 -> req drops and FAULT is entered 20 cycles after the req rise.
REQ-040 In RUN, sys_en falls with T_MUTE_CYC=8 -> nmute=0 next cycle, nenable=1 eight cycles later, state OFF.
REQ-041 resetb pulsed low during INIT with req high -> all outputs at reset values immediately, state_mon=0.

Source files
------------

// File: rtl/toi2s_pkg.sv
// toi2s_pkg: amplifier power sequencer types and the amp register init table
package toi2s_pkg;
  typedef enum logic [2:0] {
    S_OFF, S_EN_WAIT, S_INIT, S_LOCK_WAIT, S_RUN, S_MUTE_DN, S_FAULT
  } amp_seq_state_t;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } amp_init_entry_t;
  localparam int INIT_LEN = 3;
  localparam int IDX_W = $clog2(INIT_LEN + 1);
  localparam amp_init_entry_t AMP_INIT_TABLE [INIT_LEN] = '{
    '{8'h01, 8'h80},
    '{8'h02, 8'h1F},
    '{8'h03, 8'h40}
  };
endpackage

// File: rtl/amp_seq_ctrl.sv
// amp_seq_ctrl: amplifier power-up/init/unmute/power-down sequencer driving an I2C master
module amp_seq_ctrl
  import toi2s_pkg::*;
#(
  parameter int T_EN_CYC   = 1200,
  parameter int T_MUTE_CYC = 240,
  parameter int LOCK_CYC   = 4096,
  parameter int ACK_TO_CYC = 4095
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       ena,
  input  logic       sys_en,
  input  logic       audio_valid,
  output logic       i2c_req,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_ack,
  input  logic       i2c_nack,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_mon
);
  amp_seq_state_t state, ns;
  logic [15:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [1:0] retry;
  logic abort, en, stop, done, nk, tmo;
  assign en   = ena & sys_en;
  assign stop = abort | ~en;
  assign done = i2c_req & (i2c_ack | i2c_nack);
  assign nk   = i2c_req & i2c_nack;
  assign tmo  = i2c_req & ~done & (cnt == 16'(ACK_TO_CYC - 1));
  // an aborted INIT only leaves once nothing is outstanding on the I2C side
  always_comb begin
    ns = state;
    case (state)
      S_OFF:       ns = en ? S_EN_WAIT : S_OFF;
      S_EN_WAIT:   ns = !en ? S_OFF : cnt == 16'(T_EN_CYC - 1) ? S_INIT : S_EN_WAIT;
      S_INIT:      ns = (done | tmo | ~i2c_req) & stop ? S_OFF :
                        (nk & retry == 2'd2) | tmo ? S_FAULT :
                        ~i2c_req & idx == IDX_W'(INIT_LEN) ? S_LOCK_WAIT : S_INIT;
      S_LOCK_WAIT: ns = !en ? S_OFF : audio_valid & cnt == 16'(LOCK_CYC - 1) ? S_RUN : S_LOCK_WAIT;
      S_RUN:       ns = !en ? S_MUTE_DN : !audio_valid ? S_LOCK_WAIT : S_RUN;
      S_MUTE_DN:   ns = cnt == 16'(T_MUTE_CYC - 1) ? S_OFF : S_MUTE_DN;
      S_FAULT:     ns = en ? S_FAULT : S_OFF;
      default:     ns = S_OFF;
    endcase
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= S_OFF;
      state_mon   <= 3'd0;
      amp_nenable <= 1'b1;
      amp_nmute   <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      i2c_req     <= 1'b0;
      i2c_addr    <= 8'd0;
      i2c_data    <= 8'd0;
      cnt         <= 16'd0;
      idx         <= '0;
      retry       <= 2'd0;
      abort       <= 1'b0;
    end else begin
      state       <= ns;
      state_mon   <= ns;
      amp_nenable <= ns inside {S_OFF, S_FAULT};
      amp_nmute   <= ns == S_RUN;
      busy        <= ns inside {S_EN_WAIT, S_INIT, S_LOCK_WAIT, S_MUTE_DN};
      fault       <= ns == S_FAULT;
      abort       <= ns == S_INIT && stop;
      i2c_req     <= ns == S_INIT && state == S_INIT && !done;
      // the shared timer restarts on every state change, every request rise and every lock drop
      cnt         <= ns != state || (state == S_INIT && !i2c_req) || (state == S_LOCK_WAIT && !audio_valid) ?
                     16'd0 : cnt + {15'd0, cnt != 16'hFFFF};
      idx         <= state != S_INIT ? '0 : idx + IDX_W'(done & ~nk);
      retry       <= state != S_INIT ? 2'd0 : done ? (nk ? retry + 2'd1 : 2'd0) : retry;
      if (ns == S_INIT && state == S_INIT && !i2c_req)
        {i2c_addr, i2c_data} <= AMP_INIT_TABLE[idx];
    end
  end
endmodule

// File: tb/tb_amp_seq_ctrl.sv
// tb_amp_seq_ctrl: directed bench for the amplifier sequencer with an inline I2C master model
module tb_amp_seq_ctrl;
  logic clk = 1'b0, resetb = 1'b1, ena = 1'b0, sys_en = 1'b0, audio_valid = 1'b0;
  logic i2c_ack = 1'b0, i2c_nack = 1'b0;
  logic i2c_req, amp_nenable, amp_nmute, busy, fault;
  logic [7:0] i2c_addr, i2c_data;
  logic [2:0] state_mon;
  int checks = 0, failures = 0, highs;
  always #5 clk = ~clk;
  amp_seq_ctrl #(.T_EN_CYC(10), .T_MUTE_CYC(8), .LOCK_CYC(4096), .ACK_TO_CYC(20)) dut (
    .clk(clk), .resetb(resetb), .ena(ena), .sys_en(sys_en), .audio_valid(audio_valid),
    .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_data(i2c_data),
    .i2c_ack(i2c_ack), .i2c_nack(i2c_nack), .amp_nenable(amp_nenable), .amp_nmute(amp_nmute),
    .busy(busy), .fault(fault), .state_mon(state_mon)
  );
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_req();
    for (int i = 0; i < 30 && i2c_req !== 1'b1; i++) step(1);
    chk("req_rise", 16'(i2c_req), 16'd1);
  endtask
  task automatic xact(input logic [7:0] a, input logic [7:0] d, input int dly, input bit nk);
    wait_req();
    chk("addr", 16'(i2c_addr), 16'(a));
    chk("data", 16'(i2c_data), 16'(d));
    step(dly - 1);
    chk("req_held", 16'(i2c_req), 16'd1);
    if (nk) i2c_nack = 1'b1;
    else i2c_ack = 1'b1;
    step(1);
    i2c_ack = 1'b0;
    i2c_nack = 1'b0;
    chk("req_drop", 16'(i2c_req), 16'd0);
  endtask
  initial begin
    #2 resetb = 1'b0;
    step(2);
    chk("rst_state", 16'(state_mon), 16'd0);
    chk("rst_nenable", 16'(amp_nenable), 16'd1);
    chk("rst_nmute", 16'(amp_nmute), 16'd0);
    chk("rst_req", 16'(i2c_req), 16'd0);
    chk("rst_addr_data", {i2c_addr, i2c_data}, 16'd0);
    chk("rst_busy_fault", {14'd0, busy, fault}, 16'd0);
    resetb = 1'b1;
    step(1);
    // power-up: enable wait, three acked init writes, lock wait
    ena = 1'b1;
    sys_en = 1'b1;
    step(1);
    chk("enw_nenable", 16'(amp_nenable), 16'd0);
    chk("enw_busy", 16'(busy), 16'd1);
    chk("enw_state", 16'(state_mon), 16'd1);
    step(10);
    chk("init_state", 16'(state_mon), 16'd2);
    chk("init_noreq_c10", 16'(i2c_req), 16'd0);
    step(1);
    chk("init_req_c11", 16'(i2c_req), 16'd1);
    xact(8'h01, 8'h80, 5, 1'b0);
    xact(8'h02, 8'h1F, 5, 1'b0);
    xact(8'h03, 8'h40, 5, 1'b0);
    step(1);
    chk("lock_state", 16'(state_mon), 16'd3);
    chk("lock_busy", 16'(busy), 16'd1);
    chk("lock_nmute", 16'(amp_nmute), 16'd0);
    // lock: 4095 highs, a glitch, then 4096 highs
    highs = 0;
    audio_valid = 1'b1;
    for (int i = 0; i < 4095; i++) begin
      step(1);
      if (amp_nmute) highs++;
    end
    chk("nmute_early", 16'(highs), 16'd0);
    chk("lock_state2", 16'(state_mon), 16'd3);
    audio_valid = 1'b0;
    step(1);
    audio_valid = 1'b1;
    highs = 0;
    for (int i = 0; i < 4096; i++) begin
      step(1);
      if (amp_nmute) highs++;
    end
    chk("nmute_once", 16'(highs), 16'd1);
    chk("run_nmute", 16'(amp_nmute), 16'd1);
    chk("run_state", 16'(state_mon), 16'd4);
    chk("run_busy", 16'(busy), 16'd0);
    // power-down, with enable returning mid-mute
    sys_en = 1'b0;
    step(1);
    chk("mdn_nmute", 16'(amp_nmute), 16'd0);
    chk("mdn_state", 16'(state_mon), 16'd5);
    chk("mdn_busy", 16'(busy), 16'd1);
    step(2);
    sys_en = 1'b1;
    step(5);
    chk("mdn_nenable_c7", 16'(amp_nenable), 16'd0);
    chk("mdn_state_c7", 16'(state_mon), 16'd5);
    step(1);
    chk("off_nenable_c8", 16'(amp_nenable), 16'd1);
    chk("off_state_c8", 16'(state_mon), 16'd0);
    chk("off_busy", 16'(busy), 16'd0);
    step(1);
    chk("restart_state", 16'(state_mon), 16'd1);
    // entry 1 nacked three times
    xact(8'h01, 8'h80, 2, 1'b0);
    xact(8'h02, 8'h1F, 2, 1'b1);
    xact(8'h02, 8'h1F, 2, 1'b1);
    xact(8'h02, 8'h1F, 2, 1'b1);
    chk("nack_fault", 16'(fault), 16'd1);
    chk("nack_nenable", 16'(amp_nenable), 16'd1);
    chk("nack_state", 16'(state_mon), 16'd6);
    chk("nack_busy", 16'(busy), 16'd0);
    step(3);
    chk("fault_hold", 16'(fault), 16'd1);
    ena = 1'b0;
    step(1);
    chk("fault_exit_state", 16'(state_mon), 16'd0);
    chk("fault_exit_fault", 16'(fault), 16'd0);
    // no response: timeout
    ena = 1'b1;
    wait_req();
    step(19);
    chk("to_req_c19", 16'(i2c_req), 16'd1);
    chk("to_state_c19", 16'(state_mon), 16'd2);
    step(1);
    chk("to_req_c20", 16'(i2c_req), 16'd0);
    chk("to_state_c20", 16'(state_mon), 16'd6);
    chk("to_fault", 16'(fault), 16'd1);
    ena = 1'b0;
    step(1);
    chk("to_exit", 16'(state_mon), 16'd0);
    // disable during INIT waits for the outstanding ack
    ena = 1'b1;
    wait_req();
    ena = 1'b0;
    step(2);
    chk("abort_hold_state", 16'(state_mon), 16'd2);
    chk("abort_hold_req", 16'(i2c_req), 16'd1);
    i2c_ack = 1'b1;
    step(1);
    i2c_ack = 1'b0;
    chk("abort_state", 16'(state_mon), 16'd0);
    chk("abort_req", 16'(i2c_req), 16'd0);
    chk("abort_nenable", 16'(amp_nenable), 16'd1);
    // asynchronous reset mid-transaction, then a stale ack
    ena = 1'b1;
    wait_req();
    resetb = 1'b0;
    #1;
    chk("arst_req", 16'(i2c_req), 16'd0);
    chk("arst_state", 16'(state_mon), 16'd0);
    chk("arst_nenable", 16'(amp_nenable), 16'd1);
    chk("arst_nmute", 16'(amp_nmute), 16'd0);
    chk("arst_addr_data", {i2c_addr, i2c_data}, 16'd0);
    chk("arst_busy_fault", {14'd0, busy, fault}, 16'd0);
    ena = 1'b0;
    i2c_ack = 1'b1;
    step(1);
    resetb = 1'b1;
    step(2);
    i2c_ack = 1'b0;
    chk("stale_ack_state", 16'(state_mon), 16'd0);
    chk("stale_ack_req", 16'(i2c_req), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
